// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// reset_sequencer : power-on hold, then staggered per-channel reset release,
//                   with restart request, hold-off, watchdog and restart count.
// Revision 1.0
// ============================================================================
module reset_sequencer #(
  parameter int NCH         = 4,
  parameter int POR_CYCLES  = 20,
  parameter int STAGE_DLY   = 8,
  parameter int WDOG_CYCLES = 0,
  parameter int CNTW        = 16
) (
  input  logic           xclk,
  input  logic           rst,
  input  logic           req_i,
  input  logic           hold_i,
  input  logic           kick_i,
  output logic [NCH-1:0] rst_o,
  output logic           done_o,
  output logic [1:0]     state_o,
  output logic           wdog_to_o,
  output logic [7:0]     restart_cnt_o
);

  localparam int              IDXW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam longint          CNT_MAX    = (64'sd1 <<< CNTW) - 64'sd1;
  localparam logic [CNTW-1:0] POR_LAST   = CNTW'(POR_CYCLES - 1);
  localparam logic [CNTW-1:0] STAGE_LAST = CNTW'(STAGE_DLY - 1);
  localparam logic [CNTW-1:0] WDOG_LAST  = (WDOG_CYCLES > 0) ? CNTW'(WDOG_CYCLES - 1) : '0;
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NCH - 1);

  generate
    if (NCH < 1 || POR_CYCLES < 1 || STAGE_DLY < 1 || WDOG_CYCLES < 0 ||
        longint'(POR_CYCLES) > CNT_MAX || longint'(STAGE_DLY) > CNT_MAX ||
        longint'(WDOG_CYCLES) > CNT_MAX) begin : g_cfg_err
      $error("reset_sequencer: illegal parameter set for CNTW=%0d", CNTW);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] wcnt_q, wcnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] idx_nxt;
  logic [NCH-1:0]  chan_q, chan_d;
  logic            done_q, done_d;
  logic            wdog_q, wdog_d;
  logic [7:0]      rcnt_q, rcnt_d;
  logic            do_restart;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    idx_d      = idx_q;
    chan_d     = chan_q;
    done_d     = done_q;
    wdog_d     = 1'b0;
    rcnt_d     = rcnt_q;
    do_restart = 1'b0;
    idx_nxt    = idx_q + IDXW'(1);

    case (state_q)
      ST_HOLD: begin
        // A request while already holding just restarts the POR interval.
        if (hold_i || req_i) begin
          cnt_d = '0;
        end else if (cnt_q == POR_LAST) begin
          chan_d[0] = 1'b0;
          cnt_d     = '0;
          idx_d     = '0;
          if (NCH == 1) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_STAGE;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_STAGE: begin
        if (req_i) begin
          do_restart = 1'b1;
        end else if (cnt_q == STAGE_LAST) begin
          cnt_d = '0;
          idx_d = idx_nxt;
          for (int k = 0; k < NCH; k++) begin
            if (IDXW'(k) == idx_nxt) chan_d[k] = 1'b0;
          end
          if (idx_nxt == IDX_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_RUN: begin
        if (req_i) begin
          do_restart = 1'b1;
        end else if (WDOG_CYCLES != 0) begin
          if (kick_i) begin
            wcnt_d = '0;
          end else if (wcnt_q == WDOG_LAST) begin
            wdog_d     = 1'b1;
            do_restart = 1'b1;
          end else begin
            wcnt_d = wcnt_q + CNTW'(1);
          end
        end
      end
      default: begin
        state_d = ST_HOLD;
        chan_d  = '1;
        done_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        wcnt_d  = '0;
      end
    endcase

    if (do_restart) begin
      state_d = ST_HOLD;
      chan_d  = '1;
      done_d  = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      wcnt_d  = '0;
      if (rcnt_q != 8'hFF) rcnt_d = rcnt_q + 8'd1;
    end
  end

  always_ff @(posedge xclk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      chan_q  <= '1;
      done_q  <= 1'b0;
      wdog_q  <= 1'b0;
      rcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
      wdog_q  <= wdog_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign rst_o         = chan_q;
  assign done_o        = done_q;
  assign state_o       = state_q;
  assign wdog_to_o     = wdog_q;
  assign restart_cnt_o = rcnt_q;

endmodule
`default_nettype wire
